// File: rtl/output_layer.sv
// Time-multiplexed fully-connected output layer: buffers a serial activation vector,
// runs one MAC per weight, adds bias, saturates/ReLUs and emits all neurons with one pulse.
module output_layer #(
  parameter int unsigned NUM_INPUTS   = 30,
  parameter int unsigned NUM_NEURONS  = 10,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned FRAC_BITS    = 8,
  parameter int unsigned USE_RELU     = 1,
  parameter int unsigned W_ADDR_WIDTH = $clog2(NUM_INPUTS * NUM_NEURONS),
  parameter int unsigned B_ADDR_WIDTH = $clog2(NUM_NEURONS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [DATA_WIDTH-1:0]             in_data,
  output logic                              in_ready,
  output logic [W_ADDR_WIDTH-1:0]           w_addr,
  input  logic [DATA_WIDTH-1:0]             w_data,
  output logic [B_ADDR_WIDTH-1:0]           b_addr,
  input  logic [DATA_WIDTH-1:0]             b_data,
  output logic                              out_valid,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0] out_data
);

  localparam int unsigned CNT_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam int unsigned ACC_W  = 2 * DATA_WIDTH + $clog2(NUM_INPUTS) + 1;
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam int unsigned OUT_W  = NUM_NEURONS * DATA_WIDTH;

  localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_FINAL, S_DONE} state_e;

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [CNT_W-1:0]               idx_q, idx_d;
  logic                           mac_en_q, mac_en_d;
  logic [B_ADDR_WIDTH-1:0]        neuron_q, neuron_d;
  logic [W_ADDR_WIDTH-1:0]        w_addr_q, w_addr_d;
  logic                           in_ready_q, in_ready_d;
  logic                           out_valid_q, out_valid_d;
  logic [OUT_W-1:0]               out_data_q, out_data_d;
  logic [OUT_W-1:0]               stage_q, stage_d;
  logic signed [ACC_W-1:0]        acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0]   buf_q [NUM_INPUTS];
  logic signed [DATA_WIDTH-1:0]   buf_d [NUM_INPUTS];

  logic signed [PROD_W-1:0]       prod_c;
  logic signed [SUM_W-1:0]        acc_ext_c, bias_ext_c, sum_c, shr_c;
  logic signed [DATA_WIDTH-1:0]   sat_c, res_c;

  assign in_ready  = in_ready_q;
  assign w_addr    = w_addr_q;
  assign b_addr    = neuron_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Product for the address issued last cycle, plus bias/scale/saturate of the finished sum
  always_comb begin
    prod_c     = buf_q[idx_q] * $signed(w_data);
    acc_ext_c  = SUM_W'(acc_q);
    bias_ext_c = SUM_W'($signed(b_data)) <<< FRAC_BITS;
    sum_c      = acc_ext_c + bias_ext_c;
    shr_c      = sum_c >>> FRAC_BITS;
    if (shr_c > SUM_W'(OUT_MAX)) begin
      sat_c = OUT_MAX;
    end else if (shr_c < SUM_W'(OUT_MIN)) begin
      sat_c = OUT_MIN;
    end else begin
      sat_c = DATA_WIDTH'(shr_c);
    end
    res_c = sat_c;
    if ((USE_RELU != 0) && sat_c[DATA_WIDTH-1]) begin
      res_c = '0;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    neuron_d   = neuron_q;
    w_addr_d   = w_addr_q;
    buf_d      = buf_q;
    acc_d      = acc_q;
    stage_d    = stage_q;
    out_data_d = out_data_q;
    mac_en_d   = (state_q == S_MAC);
    idx_d      = cnt_q;

    if (mac_en_q) begin
      acc_d = acc_q + ACC_W'(prod_c);
    end

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          buf_d[cnt_q] = in_data;
          if (cnt_q == CNT_W'(NUM_INPUTS - 1)) begin
            cnt_d   = '0;
            state_d = S_MAC;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_MAC: begin
        if (cnt_q == CNT_W'(NUM_INPUTS - 1)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          w_addr_d = w_addr_q + W_ADDR_WIDTH'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_FINAL;
      end
      S_FINAL: begin
        acc_d = '0;
        for (int k = 0; k < NUM_NEURONS; k++) begin
          if (neuron_q == B_ADDR_WIDTH'(k)) begin
            stage_d[k*DATA_WIDTH +: DATA_WIDTH] = res_c;
          end
        end
        if (neuron_q == B_ADDR_WIDTH'(NUM_NEURONS - 1)) begin
          neuron_d   = '0;
          out_data_d = stage_d;
          state_d    = S_DONE;
        end else begin
          neuron_d = neuron_q + B_ADDR_WIDTH'(1);
          w_addr_d = w_addr_q + W_ADDR_WIDTH'(1);
          state_d  = S_MAC;
        end
      end
      S_DONE: begin
        w_addr_d = '0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      mac_en_q    <= 1'b0;
      neuron_q    <= '0;
      w_addr_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      stage_q     <= '0;
      acc_q       <= '0;
      buf_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      mac_en_q    <= mac_en_d;
      neuron_q    <= neuron_d;
      w_addr_q    <= w_addr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      stage_q     <= stage_d;
      acc_q       <= acc_d;
      buf_q       <= buf_d;
    end
  end

endmodule

// File: tb/tb_output_layer.sv
// Directed bench for output_layer: a default-size instance plus two 4x3 instances
// (ReLU on/off) sharing stimulus, each fed by synchronous weight ROM models.
module tb_output_layer;

  localparam int unsigned N  = 30;
  localparam int unsigned M  = 10;
  localparam int unsigned SN = 4;
  localparam int unsigned SM = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, out_valid;
  logic [15:0]  in_data, w_data, b_data;
  logic [8:0]   w_addr;
  logic [3:0]   b_addr;
  logic [159:0] out_data;

  logic         s_in_valid;
  logic [15:0]  s_in_data;
  logic         r_in_ready, r_out_valid, n_in_ready, n_out_valid;
  logic [15:0]  r_w_data, r_b_data, n_w_data, n_b_data;
  logic [3:0]   r_w_addr, n_w_addr;
  logic [1:0]   r_b_addr, n_b_addr;
  logic [47:0]  r_out_data, n_out_data;

  logic [15:0]  wrom [N*M];
  logic [15:0]  brom [M];
  logic [15:0]  swrom [SN*SM];
  logic [15:0]  sbrom [SM];
  logic [15:0]  vec_q [$];

  int n_vec = 0;
  int n_err = 0;

  output_layer u_big (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .w_addr(w_addr), .w_data(w_data), .b_addr(b_addr), .b_data(b_data),
    .out_valid(out_valid), .out_data(out_data)
  );

  output_layer #(.NUM_INPUTS(SN), .NUM_NEURONS(SM), .USE_RELU(1)) u_relu (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(r_in_ready),
    .w_addr(r_w_addr), .w_data(r_w_data), .b_addr(r_b_addr), .b_data(r_b_data),
    .out_valid(r_out_valid), .out_data(r_out_data)
  );

  output_layer #(.NUM_INPUTS(SN), .NUM_NEURONS(SM), .USE_RELU(0)) u_norelu (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(n_in_ready),
    .w_addr(n_w_addr), .w_data(n_w_data), .b_addr(n_b_addr), .b_data(n_b_data),
    .out_valid(n_out_valid), .out_data(n_out_data)
  );

  always @(posedge clk) begin
    w_data   <= wrom[w_addr];
    r_w_data <= swrom[r_w_addr];
    n_w_data <= swrom[n_w_addr];
  end
  assign b_data   = brom[b_addr];
  assign r_b_data = sbrom[r_b_addr];
  assign n_b_data = sbrom[n_b_addr];

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill_big(input logic [15:0] x, input logic [15:0] w);
    vec_q = {};
    for (int i = 0; i < N; i++) vec_q.push_back(x);
    for (int i = 0; i < N*M; i++) wrom[i] = w;
    for (int i = 0; i < M; i++) brom[i] = 16'h0000;
  endtask

  task automatic fill_small(input logic [15:0] x, input logic [15:0] w);
    vec_q = {};
    for (int i = 0; i < SN; i++) vec_q.push_back(x);
    for (int i = 0; i < SN*SM; i++) swrom[i] = w;
    for (int i = 0; i < SM; i++) sbrom[i] = 16'h0000;
  endtask

  task automatic send_vec(input bit sel);
    foreach (vec_q[i]) begin
      if (sel) begin s_in_valid = 1'b1; s_in_data = vec_q[i]; end
      else     begin in_valid   = 1'b1; in_data   = vec_q[i]; end
      @(posedge clk); #1;
    end
    in_valid   = 1'b0;
    s_in_valid = 1'b0;
  endtask

  // Called #1 after the edge that took the last beat; cyc counts cycles from that edge.
  task automatic wait_pulse(input bit sel, input bit junk, output int cyc);
    bit         addr_bad = 1'b0;
    bit         rdy_bad  = 1'b0;
    logic [8:0] prev;
    prev = w_addr;
    cyc  = 1;
    if (!sel) check_eq("w_addr_start", 160'(w_addr), 160'(0));
    while (!(sel ? r_out_valid : out_valid) && cyc < 2000) begin
      if (!sel) begin
        if (w_addr != prev) begin
          if (w_addr != prev + 9'd1) addr_bad = 1'b1;
          prev = w_addr;
        end
        if (in_ready) rdy_bad = 1'b1;
      end
      if (junk) begin in_valid = 1'b1; in_data = 16'($urandom); end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (!sel) begin
      check_eq("w_addr_order", 160'(addr_bad), 160'(0));
      check_eq("in_ready_busy", 160'(rdy_bad), 160'(0));
    end
  endtask

  task automatic run_big(input string tag, input logic [159:0] exp, input bit junk);
    int cyc;
    send_vec(1'b0);
    wait_pulse(1'b0, junk, cyc);
    check_eq({tag, "_latency"}, 160'(cyc), 160'(321));
    check_eq({tag, "_data"}, out_data, exp);
    check_eq({tag, "_w_addr_last"}, 160'(w_addr), 160'(N*M-1));
    @(posedge clk); #1;
    check_eq({tag, "_pulse_width"}, 160'(out_valid), 160'(0));
    check_eq({tag, "_ready_after"}, 160'(in_ready), 160'(1));
    check_eq({tag, "_data_hold"}, out_data, exp);
  endtask

  task automatic run_small(input string tag, input logic [47:0] exp_r, input logic [47:0] exp_n);
    int cyc;
    send_vec(1'b1);
    wait_pulse(1'b1, 1'b0, cyc);
    check_eq({tag, "_latency"}, 160'(cyc), 160'(SM*(SN+2)+1));
    check_eq({tag, "_relu"}, 160'(r_out_data), 160'(exp_r));
    check_eq({tag, "_norelu_valid"}, 160'(n_out_valid), 160'(1));
    check_eq({tag, "_norelu"}, 160'(n_out_data), 160'(exp_n));
    @(posedge clk); #1;
    check_eq({tag, "_pulse_width"}, 160'(r_out_valid), 160'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [159:0] exp;
    logic [15:0]  wk, best;
    int           k, best_idx;
    bit           seen;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; s_in_valid = 1'b0; s_in_data = '0;
    fill_big(16'h0100, 16'h0080);
    fill_small(16'h0100, 16'h0100);
    #3;
    check_eq("rst_in_ready", 160'(in_ready), 160'(1));
    check_eq("rst_out_valid", 160'(out_valid), 160'(0));
    check_eq("rst_out_data", out_data, 160'(0));
    check_eq("rst_w_addr", 160'(w_addr), 160'(0));
    check_eq("rst_b_addr", 160'(b_addr), 160'(0));
    check_eq("rst_small_ready", 160'(r_in_ready), 160'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 30 x (1.0 * 0.5) = 15.0 per neuron
    fill_big(16'h0100, 16'h0080);
    run_big("basic", {M{16'h0F00}}, 1'b0);
    run_big("hold", {M{16'h0F00}}, 1'b1);

    // Neuron 7 weight 0x40 beats neuron 9 weight 0x28
    fill_big(16'h0100, 16'h0000);
    for (int n = 0; n < M; n++) begin
      wk = (n == 7) ? 16'h0040 : 16'(4 * (n + 1));
      for (int i = 0; i < N; i++) wrom[n*N + i] = wk;
      exp[n*16 +: 16] = 16'(30 * int'(wk));
    end
    run_big("rank", exp, 1'b0);
    best = '0; best_idx = 0;
    for (int n = 0; n < M; n++) begin
      if (out_data[n*16 +: 16] > best) begin best = out_data[n*16 +: 16]; best_idx = n; end
    end
    check_eq("rank_argmax", 160'(best_idx), 160'(7));
    check_eq("rank_slot7", 160'(out_data[7*16 +: 16]), 160'(16'h0780));

    fill_big(16'h7FFF, 16'h7FFF);
    run_big("sat_pos", {M{16'h7FFF}}, 1'b0);

    // Reset in the middle of neuron 5
    fill_big(16'h0100, 16'h0080);
    send_vec(1'b0);
    k = 0;
    while (b_addr != 4'd5 && k < 400) begin @(posedge clk); #1; k++; end
    check_eq("rst_mid_reach", 160'(b_addr), 160'(5));
    check_eq("rst_mid_hold", out_data, {M{16'h7FFF}});
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid_valid", 160'(out_valid), 160'(0));
    check_eq("rst_mid_data", out_data, 160'(0));
    check_eq("rst_mid_w_addr", 160'(w_addr), 160'(0));
    check_eq("rst_mid_b_addr", 160'(b_addr), 160'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (400) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    check_eq("rst_mid_no_pulse", 160'(seen), 160'(0));
    check_eq("rst_mid_ready", 160'(in_ready), 160'(1));
    run_big("fresh", {M{16'h0F00}}, 1'b0);

    fill_big(16'h7FFF, 16'h8000);
    run_big("sat_neg_relu", 160'(0), 1'b0);

    // 4 x 1.0 = 4.0, plus biases 1.0 / -6.0 / 0.0
    fill_small(16'h0100, 16'h0100);
    sbrom[0] = 16'h0100; sbrom[1] = 16'hFA00; sbrom[2] = 16'h0000;
    run_small("bias", {16'h0400, 16'h0000, 16'h0500}, {16'h0400, 16'hFE00, 16'h0500});

    fill_small(16'h7FFF, 16'h7FFF);
    run_small("s_sat_pos", {SM{16'h7FFF}}, {SM{16'h7FFF}});

    fill_small(16'h7FFF, 16'h8000);
    run_small("s_sat_neg", 48'h0, {SM{16'h8000}});

    // 1 LSB * -0.5 = -0.5/256 floors to -1 LSB
    fill_small(16'h0000, 16'hFF80);
    vec_q[0] = 16'h0001;
    run_small("floor", 48'h0, {SM{16'hFFFF}});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
